// File: rtl/pkt_framer.sv
// pkt_framer: buffers a valid/ready sample stream in a FIFO and emits
// fixed-length packets as contiguous valid beats. o_last marks the final
// beat, and a programmable idle gap separates packets. The output side
// has no backpressure. A packet only starts once a whole packet is
// buffered, so beats within a packet are never interrupted.
//
// Handshake: an input sample is written when i_valid && o_ready are both
// high at a rising edge of i_clk. o_ready depends only on FIFO occupancy,
// never on a same-cycle read. The output valid carries no ready: each
// beat with o_valid high is a complete transfer.
module pkt_framer #(
  parameter int G_BIT_WIDTH  = 8,
  parameter int G_PKT_LEN    = 11,
  parameter int G_GAP        = 10,
  parameter int G_FIFO_DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic [G_BIT_WIDTH-1:0] i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [G_BIT_WIDTH-1:0] o_data,
  output logic                   o_valid,
  output logic                   o_last,
  output logic                   o_busy,
  output logic [15:0]            o_pkt_cnt
);

  // Occupancy needs one bit more than the pointers so that "full" is
  // representable.
  localparam int CW = $clog2(G_FIFO_DEPTH) + 1;
  localparam int PW = (G_FIFO_DEPTH > 1) ? $clog2(G_FIFO_DEPTH) : 1;
  localparam int GW = (G_GAP > 0) ? $clog2(G_GAP + 1) : 1;

  localparam logic [CW-1:0] DEPTH_C   = CW'(G_FIFO_DEPTH);
  localparam logic [CW-1:0] PKT_LEN_C = CW'(G_PKT_LEN);
  localparam logic [PW-1:0] PTR_MAX_C = PW'(G_FIFO_DEPTH - 1);
  localparam logic [GW-1:0] GAP_C     = GW'(G_GAP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [G_BIT_WIDTH-1:0] mem_q [G_FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   wr_en;
  logic                   rd_en;
  logic                   fifo_ready;

  // Packet FSM and registered outputs
  state_t                 state_q, state_d;
  logic [CW-1:0]          beat_q, beat_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [G_BIT_WIDTH-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic [15:0]            pkt_cnt_q, pkt_cnt_d;
  logic                   end_pkt;

  // Pointer advance with explicit wrap so non-trivial depths stay correct.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PTR_MAX_C) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  // o_ready is held low while reset is asserted, otherwise it follows
  // occupancy alone.
  assign fifo_ready = (count_q < DEPTH_C);
  assign wr_en      = i_valid && fifo_ready;

  // FIFO pointer and occupancy next-state. Simultaneous push and pop leave
  // the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (rd_en) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Packet sequencing: start only with a full packet buffered, send
  // G_PKT_LEN beats back to back, then idle for G_GAP cycles.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    gap_d     = gap_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    pkt_cnt_d = pkt_cnt_q;
    rd_en     = 1'b0;
    end_pkt   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_en && (count_q >= PKT_LEN_C)) begin
          rd_en   = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          valid_d = 1'b1;
          beat_d  = CW'(1);
          if (G_PKT_LEN == 1) begin
            last_d  = 1'b1;
            end_pkt = 1'b1;
          end else begin
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        // A started packet always completes, whatever i_en does.
        rd_en   = 1'b1;
        data_d  = mem_q[rd_ptr_q];
        valid_d = 1'b1;
        beat_d  = beat_q + CW'(1);
        if ((beat_q + CW'(1)) == PKT_LEN_C) begin
          last_d  = 1'b1;
          end_pkt = 1'b1;
        end
      end
      S_GAP: begin
        gap_d = gap_q - GW'(1);
        if (gap_q <= GW'(1)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The edge that registers the final beat closes the packet.
    if (end_pkt) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
      if (G_GAP > 0) begin
        state_d = S_GAP;
        gap_d   = GAP_C;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // FIFO storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  // All control state and registered outputs, cleared asynchronously.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= S_IDLE;
      beat_q    <= '0;
      gap_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      beat_q    <= beat_d;
      gap_q     <= gap_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign o_ready   = fifo_ready && !i_rst;
  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_last    = last_q;
  assign o_busy    = (state_q != S_IDLE);
  assign o_pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_pkt_framer.sv
// Testbench for pkt_framer: directed scenarios plus a randomized run,
// checked by a scoreboard fed from a packet-level reference model.
module tb_pkt_framer;

  localparam int W = 8;
  localparam int L = 11;
  localparam int G = 10;
  localparam int D = 16;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         i_rst;
  logic         i_en;
  logic [W-1:0] i_data;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] o_data;
  logic         o_valid;
  logic         o_last;
  logic         o_busy;
  logic [15:0]  o_pkt_cnt;

  pkt_framer #(
    .G_BIT_WIDTH (W),
    .G_PKT_LEN   (L),
    .G_GAP       (G),
    .G_FIFO_DEPTH(D)
  ) dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_en     (i_en),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_last   (o_last),
    .o_busy   (o_busy),
    .o_pkt_cnt(o_pkt_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_eq(input string name, input longint act, input longint exp);
    check(act == exp, name, act, exp);
  endtask

  // Reference model: every accepted sample is expected back in order;
  // packets are consecutive groups of L, the last of each group carries last.
  logic [W:0]   exp_q[$];
  int           acc_total  = 0;
  bit           acc_s      = 1'b0;
  logic [W-1:0] acc_d;

  always @(negedge clk) begin
    acc_s = i_valid && o_ready && !i_rst;
    acc_d = i_data;
  end

  always @(posedge clk) begin
    if (acc_s && !i_rst) begin
      exp_q.push_back({((acc_total % L) == (L - 1)), acc_d});
      acc_total++;
      acc_s = 1'b0;
    end
  end

  // Monitor: pops the expected queue on every output beat and checks
  // ordering, framing, contiguity, gap length and the packet counter.
  bit         in_pkt     = 1'b0;
  bit         seen_last  = 1'b0;
  bit         en_prev    = 1'b0;
  int         low_cnt    = 0;
  int         last_gap   = -1;
  int         model_pkts = 0;
  logic [W:0] e;

  always @(negedge clk) begin
    if (i_rst) begin
      in_pkt     = 1'b0;
      seen_last  = 1'b0;
      low_cnt    = 0;
      model_pkts = 0;
    end else begin
      if (o_valid) begin
        if (!in_pkt) begin
          check(en_prev, "start_while_en_low", en_prev, 1);
          if (seen_last) begin
            check(low_cnt >= G, "gap_min", low_cnt, G);
            last_gap = low_cnt;
          end
          in_pkt = 1'b1;
        end
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_beat", o_data, -1);
        end else begin
          e = exp_q.pop_front();
          chk_eq("beat_data", o_data, e[W-1:0]);
          chk_eq("beat_last", o_last, e[W]);
          if (e[W]) model_pkts++;
          chk_eq("beat_pkt_cnt", o_pkt_cnt, model_pkts % 65536);
        end
        if (o_last) begin
          in_pkt    = 1'b0;
          seen_last = 1'b1;
          low_cnt   = 0;
        end
      end else begin
        if (in_pkt) begin
          check(1'b0, "packet_broken", 0, 1);
          in_pkt = 1'b0;
        end
        if (seen_last) low_cnt++;
      end
    end
    en_prev = i_en;
  end

  // Driver tasks
  task automatic clear_model();
    exp_q.delete();
    acc_total = 0;
    acc_s     = 1'b0;
    last_gap  = -1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    clear_model();
    @(posedge clk);
    @(posedge clk); #1;
    i_rst = 1'b0;
  endtask

  task automatic write_seq(input int start, input int n, input bit toggle, input bit chk_novalid);
    bit a;
    int t;
    for (int k = 0; k < n; k++) begin
      i_valid = 1'b1;
      i_data  = W'(start + k);
      t = 0;
      a = 1'b0;
      while (!a && t < 200) begin
        @(negedge clk) a = o_ready;
        @(posedge clk); #1;
        t++;
      end
      if (!a) check(1'b0, "write_timeout", t, 200);
      if (chk_novalid && k < n - 1) chk_eq("no_valid_before_full", o_valid, 0);
      if (toggle) begin
        i_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    i_en = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!(exp_q.size() < L && !o_busy && !o_valid) && t < 1000);
    if (t >= 1000) check(1'b0, "drain_timeout", exp_q.size(), 0);
  endtask

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int vcnt;
    i_rst   = 1'b0;
    i_en    = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;

    // Reset state, asserted asynchronously before any clock edge.
    #2 i_rst = 1'b1;
    clear_model();
    #1;
    chk_eq("rst_valid", o_valid, 0);
    chk_eq("rst_last", o_last, 0);
    chk_eq("rst_ready", o_ready, 0);
    chk_eq("rst_busy", o_busy, 0);
    chk_eq("rst_pkt_cnt", o_pkt_cnt, 0);
    chk_eq("rst_data", o_data, 0);
    @(posedge clk);
    @(posedge clk); #1;
    i_rst = 1'b0;
    #1;
    chk_eq("ready_after_rst", o_ready, 1);

    // 1: single packet 1..11
    write_seq(1, 11, 1'b0, 1'b0);
    wait_drain();
    chk_eq("t1_pkt_cnt", o_pkt_cnt, 1);
    chk_eq("t1_busy", o_busy, 0);

    // 2: two packets back to back with an exact gap
    do_reset();
    write_seq(1, 22, 1'b0, 1'b0);
    wait_drain();
    chk_eq("t2_pkt_cnt", o_pkt_cnt, 2);
    chk_eq("t2_gap", last_gap, G);

    // 3: fill while disabled, then release
    i_en = 1'b0;
    do_reset();
    write_seq(1, 16, 1'b0, 1'b0);
    chk_eq("t3_full_ready", o_ready, 0);
    i_valid = 1'b1;
    i_data  = W'(17);
    repeat (3) begin
      @(negedge clk);
      chk_eq("t3_held_ready", o_ready, 0);
    end
    @(posedge clk); #1;
    i_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_eq("t3_first_beat", o_valid, 1);
    chk_eq("t3_ready_after_pop", o_ready, 1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    wait_drain();
    chk_eq("t3_pkt_cnt", o_pkt_cnt, 1);
    chk_eq("t3_leftover", exp_q.size(), 6);

    // 4: sparse writes, packet waits for all 11
    do_reset();
    write_seq(1, 11, 1'b1, 1'b1);
    wait_drain();
    chk_eq("t4_pkt_cnt", o_pkt_cnt, 1);

    // 5: reset during beat 5
    do_reset();
    write_seq(1, 11, 1'b0, 1'b0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(o_valid && o_data == W'(5)) && t < 100);
    chk_eq("t5_found_beat5", o_data, 5);
    #1 i_rst = 1'b1;
    clear_model();
    #1;
    chk_eq("t5_valid", o_valid, 0);
    chk_eq("t5_last", o_last, 0);
    chk_eq("t5_pkt_cnt", o_pkt_cnt, 0);
    chk_eq("t5_ready", o_ready, 0);
    @(posedge clk);
    @(posedge clk); #1;
    i_rst = 1'b0;
    write_seq(100, 11, 1'b0, 1'b0);
    wait_drain();
    chk_eq("t5_pkt_cnt_after", o_pkt_cnt, 1);

    // 6: drop i_en during beat 3 of the first of two packets
    do_reset();
    fork
      write_seq(1, 22, 1'b0, 1'b0);
      begin
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!(o_valid && o_data == W'(3)) && t < 100);
        #1 i_en = 1'b0;
      end
    join
    t = 0;
    while (!(model_pkts == 1 && !o_busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk_eq("t6_first_done", model_pkts, 1);
    vcnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (o_valid) vcnt++;
    end
    chk_eq("t6_no_valid_while_disabled", vcnt, 0);
    chk_eq("t6_held_in_fifo", exp_q.size(), 11);
    wait_drain();
    chk_eq("t6_pkt_cnt", o_pkt_cnt, 2);

    // 7: randomized traffic with random enable toggling
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      i_valid = ($urandom_range(0, 3) != 0);
      i_data  = W'($urandom);
      if ($urandom_range(0, 39) == 0) i_en = ~i_en;
    end
    i_valid = 1'b0;
    wait_drain();
    chk_eq("t7_pkt_cnt", o_pkt_cnt, (acc_total / L) % 65536);
    chk_eq("t7_leftover", exp_q.size(), acc_total % L);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
